// File: rtl/alu_execute_unit_if.sv
// alu_execute_unit_if: operand/opcode request and result response handshake bundle
interface alu_execute_unit_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         alu_operation;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic               illegal_op;
  modport master (
    output in_valid, alu_operation, a, b, shamt, out_ready,
    input  in_ready, out_valid, result, zero, illegal_op
  );
  modport slave (
    input  in_valid, alu_operation, a, b, shamt, out_ready,
    output in_ready, out_valid, result, zero, illegal_op
  );
endinterface

// File: rtl/alu_execute_unit.sv
// alu_execute_unit: handshaked execute stage, single-cycle logic/arith ops and 1-bit-per-cycle shifts
module alu_execute_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input logic             clk,
  input logic             reset,
  alu_execute_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t             r_state;
  logic [WIDTH-1:0]   r_shreg;
  logic [WIDTH-1:0]   r_result;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_left;
  logic               r_zero;
  logic               r_illegal;
  logic               r_out_valid;
  logic [WIDTH-1:0]   w_res;
  logic [WIDTH-1:0]   w_shift;
  logic               w_is_shift;
  logic               w_illegal;
  always_comb begin
    w_res = '0;
    case (bus.alu_operation)
      4'b0000: w_res = bus.a & bus.b;
      4'b0001: w_res = bus.a | bus.b;
      4'b0010: w_res = ~(bus.a | bus.b);
      4'b0011: w_res = bus.a + bus.b;
      4'b0100: w_res = bus.a - bus.b;
      4'b0101: w_res = bus.b << (WIDTH / 2);
      4'b0110, 4'b0111: w_res = bus.b;
      default: w_res = '0;
    endcase
  end
  assign w_illegal  = bus.alu_operation[3];
  assign w_is_shift = bus.alu_operation[3:1] == 3'b011;
  assign w_shift    = r_left ? r_shreg << 1 : r_shreg >> 1;
  assign bus.in_ready   = reset && r_state == IDLE;
  assign bus.out_valid  = r_out_valid;
  assign bus.result     = r_result;
  assign bus.zero       = r_zero;
  assign bus.illegal_op = r_illegal;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_left      <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          if (w_is_shift && bus.shamt != '0) begin
            r_shreg <= bus.b;
            r_cnt   <= bus.shamt;
            r_left  <= bus.alu_operation[0];
            r_state <= SHIFT;
          end else begin
            r_result    <= w_res;
            r_zero      <= w_res == '0;
            r_illegal   <= w_illegal;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        SHIFT: begin
          r_shreg <= w_shift;
          r_cnt   <= r_cnt - SHAMT_W'(1);
          if (r_cnt == SHAMT_W'(1)) begin
            r_result    <= w_shift;
            r_zero      <= w_shift == '0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_execute_unit.sv
// tb_alu_execute_unit: directed vectors, expected responses queued and checked by an independent monitor
module tb_alu_execute_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  alu_execute_unit_if bus();
  alu_execute_unit dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [31:0] res;
    logic        zr;
    logic        il;
    int          lat;
    int          t_acc;
  } exp_t;
  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_valid = 1'b0;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset && bus.out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result %h expected no output", bus.result);
      end else begin
        if (!prev_valid) chk("latency", cyc - sb[0].t_acc + 1, sb[0].lat);
        chk("result", bus.result, sb[0].res);
        chk("zero", {31'b0, bus.zero}, {31'b0, sb[0].zr});
        chk("illegal_op", {31'b0, bus.illegal_op}, {31'b0, sb[0].il});
        chk("in_ready_busy", {31'b0, bus.in_ready}, 32'd0);
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
    prev_valid = reset && bus.out_valid;
  end
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] res, input logic zr,
                       input logic il, input int lat);
    int n = 0;
    exp_t e;
    @(posedge clk);
    #1;
    bus.alu_operation = op;
    bus.a = a;
    bus.b = b;
    bus.shamt = sh;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready 0 expected 1");
    end else begin
      e = '{res, zr, il, lat, cyc + 1};
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = ~a;
    bus.b = ~b;
    bus.alu_operation = 4'b0100;
    bus.shamt = ~sh;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending %0d expected 0", sb.size());
      sb.delete();
    end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.alu_operation = '0;
    bus.a = '0;
    bus.b = '0;
    bus.shamt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_zero", {31'b0, bus.zero}, 32'd0);
    chk("rst_illegal", {31'b0, bus.illegal_op}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {31'b0, bus.in_ready}, 32'd1);
    issue(4'b0011, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 1'b0, 1'b0, 1);
    issue(4'b0100, 32'h0000_0005, 32'h0000_0005, 5'd0, 32'h0000_0000, 1'b1, 1'b0, 1);
    issue(4'b0111, 32'h1234_5678, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 32);
    issue(4'b0110, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0, 5);
    issue(4'b0110, 32'h0, 32'hF000_000F, 5'd1, 32'h7800_0007, 1'b0, 1'b0, 2);
    drain();
    bus.out_ready = 1'b0;
    issue(4'b0001, 32'h0000_00F0, 32'h0000_000F, 5'd0, 32'h0000_00FF, 1'b0, 1'b0, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("held_valid", {31'b0, bus.out_valid}, 32'd1);
      @(posedge clk);
      #1;
      bus.a = $urandom;
      bus.b = $urandom;
      bus.in_valid = 1'b1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    issue(4'b1001, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0, 32'h0, 1'b1, 1'b1, 1);
    issue(4'b0000, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, 32'h0F00_0F00, 1'b0, 1'b0, 1);
    issue(4'b0101, 32'hFFFF_FFFF, 32'h0000_1234, 5'd0, 32'h1234_0000, 1'b0, 1'b0, 1);
    issue(4'b0010, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    issue(4'b0111, 32'h0, 32'hA5A5_0001, 5'd0, 32'hA5A5_0001, 1'b0, 1'b0, 1);
    issue(4'b0110, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 1);
    drain();
    issue(4'b0111, 32'h0, 32'h0000_0001, 5'd20, 32'h0010_0000, 1'b0, 1'b0, 21);
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", {31'b0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("abort_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("abort_result", bus.result, 32'd0);
    sb.delete();
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    repeat (25) @(negedge clk);
    issue(4'b0011, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0, 32'h0000_0001, 1'b0, 1'b0, 1);
    drain();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
